mult_seq_param: RTL and testbench

MULT_SEQ_PARAM -- requirements
Module: mult_seq_param

---
 rtl/mult_pkg.sv | 11 +
 rtl/mult_seq_datapath.sv | 86 ++++++++
 rtl/mult_seq_param.sv | 76 +++++++
 tb/tb_mult_seq_param.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared FSM encoding for the sequential multiplier.
// Optional signed support is selected with the MULT_SIGNED_EN macro.
package mult_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/mult_seq_datapath.sv
// Shift-add datapath: accumulator, operand shift registers and bit counter.
// Latency: one multiplier bit per step; no backpressure, steps whenever step_i is high.
// MULT_SIGNED_EN compiles in the two's-complement MSB correction.
module mult_seq_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] result_o
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, addend, acc_sum;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sext;

`ifdef MULT_SIGNED_EN
  logic signed_q, signed_d;
  assign sext = signed_i;
`else
  logic unused_signed;
  assign unused_signed = signed_i;
  assign sext = 1'b0;
`endif

  assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    addend = mplier_q[0] ? mcand_q : '0;
`ifdef MULT_SIGNED_EN
    // In signed mode the multiplier MSB carries negative weight.
    if (signed_q && last_o) addend = '0 - addend;
`endif
    acc_sum  = acc_q + addend;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`ifdef MULT_SIGNED_EN
    signed_d = signed_q;
`endif
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{mcand_i[WIDTH-1] & sext}}, mcand_i};
      mplier_d = mplier_i;
      cnt_d    = '0;
`ifdef MULT_SIGNED_EN
      signed_d = signed_i;
`endif
    end else if (step_i) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  assign result_o = acc_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`ifdef MULT_SIGNED_EN
      signed_q <= 1'b0;
`endif
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`ifdef MULT_SIGNED_EN
      signed_q <= signed_d;
`endif
    end
  end
endmodule

// File: rtl/mult_seq_param.sv
// Sequential WIDTH x WIDTH multiplier, FSM control around a shift-add datapath.
// Latency WIDTH+1 cycles from accept to done; start is ignored while busy (no queueing).
// MULT_SIGNED_EN enables signed_mode; otherwise every operation is unsigned.
module mult_seq_param
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done,
  output logic                 busy,
  output logic [STATE_W-1:0]   state
);
  state_e             state_q;
  logic [2*WIDTH-1:0] product_q;
  logic               done_q, busy_q;
  logic               dp_load, dp_step, dp_last;
  logic [2*WIDTH-1:0] dp_result;

  assign dp_load = (state_q == IDLE) && start;
  assign dp_step = (state_q == CALC);

  mult_seq_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (dp_load),
    .step_i   (dp_step),
    .signed_i (signed_mode),
    .mcand_i  (multiplicand),
    .mplier_i (multiplier),
    .last_o   (dp_last),
    .result_o (dp_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      product_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= CALC;
          busy_q  <= 1'b1;
        end
        CALC: if (dp_last) begin
          state_q   <= DONE;
          done_q    <= 1'b1;
          product_q <= dp_result;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign product = product_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign state   = state_q;
endmodule

// File: tb/tb_mult_seq_param.sv
// Bench for mult_seq_param: WIDTH=8 vector table and corner sequences, WIDTH=16 random sweep.
// Signed expectations apply only when MULT_SIGNED_EN is defined.
module tb_mult_seq_param;
`ifdef MULT_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, sm8, start16, sm16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic [15:0] prod8;
  logic [31:0] prod16;
  logic        done8, busy8, done16, busy16;
  logic [1:0]  state8, state16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_seq_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .multiplicand(a8), .multiplier(b8), .product(prod8),
    .done(done8), .busy(busy8), .state(state8)
  );

  mult_seq_param #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
    .multiplicand(a16), .multiplier(b16), .product(prod16),
    .done(done16), .busy(busy16), .state(state16)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp_u;
    logic [15:0] exp_s;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Lat counts rising edges from acceptance up to the edge that samples done high.
  task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      output logic [15:0] p, output int lat);
    @(negedge clk);
    a8 = a; b8 = b; sm8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    p = prod8;
  endtask

  task automatic mul16(input logic [15:0] a, input logic [15:0] b, input logic s,
                       output logic [31:0] p, output int lat);
    @(negedge clk);
    a16 = a; b16 = b; sm16 = s; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    lat = 1;
    while (!done16 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    p = prod16;
  endtask

  initial begin
    logic [15:0] p8, e8;
    logic [31:0] p16, e16;
    logic [15:0] ra, rb;
    logic        rs;
    int          lat, ndone, first_k, second_k;
    logic [15:0] first_p, second_p;

    vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 16'hFE01};
    vecs[1] = '{8'h80, 8'h80, 1'b1, 16'h4000, 16'h4000};
    vecs[2] = '{8'hFF, 8'h03, 1'b1, 16'h02FD, 16'hFFFD};
    vecs[3] = '{8'h7F, 8'h80, 1'b1, 16'h3F80, 16'hC080};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 16'hFE01, 16'h0001};
    vecs[5] = '{8'h00, 8'h4D, 1'b0, 16'h0000, 16'h0000};
    vecs[6] = '{8'h0D, 8'h0B, 1'b0, 16'h008F, 16'h008F};
    vecs[7] = '{8'h81, 8'h02, 1'b1, 16'h0102, 16'hFF02};
    vecs[8] = '{8'h05, 8'hFB, 1'b1, 16'h04E7, 16'hFFE7};
    vecs[9] = '{8'hC8, 8'h64, 1'b0, 16'h4E20, 16'h4E20};

    rst_n = 1'b0; start8 = 1'b1; sm8 = 1'b0; a8 = 8'd9; b8 = 8'd9;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    #2;
    chk("reset_product", 64'(prod8), 64'h0);
    chk("reset_done", 64'(done8), 64'h0);
    chk("reset_busy", 64'(busy8), 64'h0);
    chk("reset_state", 64'(state8), 64'h0);
    repeat (2) @(negedge clk);
    chk("start_in_reset_ignored", 64'(state8), 64'h0);
    start8 = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      e8 = (vecs[i].s && SIGNED_BUILD) ? vecs[i].exp_s : vecs[i].exp_u;
      mul8(vecs[i].a, vecs[i].b, vecs[i].s, p8, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
      chk($sformatf("vec%0d_product", i), 64'(p8), 64'(e8));
      chk($sformatf("vec%0d_state_done", i), 64'(state8), 64'd2);
      chk($sformatf("vec%0d_busy_done", i), 64'(busy8), 64'd1);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), 64'(done8), 64'd0);
      chk($sformatf("vec%0d_idle_busy", i), 64'(busy8), 64'd0);
      chk($sformatf("vec%0d_product_hold", i), 64'(prod8), 64'(e8));
    end

    // start held high: two back-to-back multiplies, done pulses 10 cycles apart.
    @(negedge clk);
    a8 = 8'd12; b8 = 8'd10; sm8 = 1'b0; start8 = 1'b1;
    ndone = 0; first_k = 0; second_k = 0; first_p = '0; second_p = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin a8 = 8'd7; b8 = 8'd9; end
      if (k == 11) start8 = 1'b0;
      if (k == 5) chk("b2b_mid_product_hold", 64'(prod8), 64'h4E20);
      if (done8) begin
        ndone++;
        if (ndone == 1) begin first_k = k; first_p = prod8; end
        if (ndone == 2) begin second_k = k; second_p = prod8; end
      end
    end
    chk("b2b_done_count", 64'(ndone), 64'd2);
    chk("b2b_first_product", 64'(first_p), 64'd120);
    chk("b2b_second_product", 64'(second_p), 64'd63);
    chk("b2b_first_latency", 64'(first_k), 64'd9);
    chk("b2b_period", 64'(second_k - first_k), 64'd10);

    // Operand changes and a start pulse during CALC must not disturb the result.
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
    ndone = 0; first_p = '0; first_k = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin start8 = 1'b0; a8 = 8'd0; b8 = 8'd0; end
      if (k == 3) start8 = 1'b1;
      if (k == 4) start8 = 1'b0;
      if (done8) begin ndone++; first_p = prod8; first_k = k; end
    end
    chk("inflight_product", 64'(first_p), 64'd20000);
    chk("inflight_done_count", 64'(ndone), 64'd1);
    chk("inflight_latency", 64'(first_k), 64'd9);

    // Reset during the 4th CALC cycle discards the multiply.
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_product", 64'(prod8), 64'h0);
    chk("rst_mid_state", 64'(state8), 64'h0);
    chk("rst_mid_busy", 64'(busy8), 64'h0);
    chk("rst_mid_done", 64'(done8), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("rst_mid_no_done", 64'(ndone), 64'd0);
    mul8(8'd3, 8'd5, 1'b0, p8, lat);
    chk("post_rst_product", 64'(p8), 64'd15);
    chk("post_rst_latency", 64'(lat), 64'd9);

    // WIDTH=16 sweep with a reference model; first two operand pairs are extremes.
    for (int i = 0; i < 40; i++) begin
      rs = i[0];
      if (i < 2) begin
        ra = (i == 0) ? 16'h8000 : 16'hFFFF;
        rb = ra;
      end else begin
        ra = 16'($urandom);
        rb = 16'($urandom);
      end
      if (rs && SIGNED_BUILD) e16 = $signed(ra) * $signed(rb);
      else e16 = 32'(ra) * 32'(rb);
      mul16(ra, rb, rs, p16, lat);
      chk($sformatf("w16_%0d_product a=%0h b=%0h s=%0d", i, ra, rb, rs), 64'(p16), 64'(e16));
      chk($sformatf("w16_%0d_latency", i), 64'(lat), 64'd17);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
